// File: rtl/plab2_proc_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : plab2_proc_mem_port_arbiter
// Description : Merges the processor imem (port 0) and dmem (port 1) val/rdy
//               request streams onto one memory port with round-robin
//               arbitration, and steers in-order responses back to the port
//               that issued them using a small port-ID tracking FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module plab2_proc_mem_port_arbiter #(
  parameter int p_num_entries = 4,
  parameter int p_req_nbits   = 77,
  parameter int p_resp_nbits  = 47
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [p_req_nbits-1:0]  in0_req_msg,
  input  logic                    in0_req_val,
  output logic                    in0_req_rdy,
  output logic [p_resp_nbits-1:0] in0_resp_msg,
  output logic                    in0_resp_val,
  input  logic                    in0_resp_rdy,

  input  logic [p_req_nbits-1:0]  in1_req_msg,
  input  logic                    in1_req_val,
  output logic                    in1_req_rdy,
  output logic [p_resp_nbits-1:0] in1_resp_msg,
  output logic                    in1_resp_val,
  input  logic                    in1_resp_rdy,

  output logic [p_req_nbits-1:0]  out_req_msg,
  output logic                    out_req_val,
  input  logic                    out_req_rdy,
  input  logic [p_resp_nbits-1:0] out_resp_msg,
  input  logic                    out_resp_val,
  output logic                    out_resp_rdy
);

  localparam int              c_PW         = $clog2(p_num_entries);
  localparam int              c_CW         = c_PW + 1;
  localparam logic [c_CW-1:0] c_FULL_COUNT = c_CW'(p_num_entries);

  logic [c_CW-1:0]          r_count;
  logic [c_PW-1:0]          r_wptr;
  logic [c_PW-1:0]          r_rptr;
  logic [p_num_entries-1:0] r_ids;
  logic                     r_prio;       // 0 favours port 0, 1 favours port 1
  logic                     r_lock;
  logic                     r_lock_port;

  logic w_full;
  logic w_empty;
  logic w_grant_val;
  logic w_grant_port;
  logic w_req_ok;
  logic w_req_fire;
  logic w_resp_ok;
  logic w_resp_fire;
  logic w_head;

  assign w_full  = (r_count == c_FULL_COUNT);
  assign w_empty = (r_count == '0);

  // Grant selection: a stalled request keeps its grant so the message stays stable
  always_comb begin
    w_grant_val  = 1'b0;
    w_grant_port = 1'b0;
    if (r_lock) begin
      w_grant_port = r_lock_port;
      w_grant_val  = r_lock_port ? in1_req_val : in0_req_val;
    end else if (in0_req_val && in1_req_val) begin
      w_grant_val  = 1'b1;
      w_grant_port = r_prio;
    end else if (in1_req_val) begin
      w_grant_val  = 1'b1;
      w_grant_port = 1'b1;
    end else if (in0_req_val) begin
      w_grant_val  = 1'b1;
    end
  end

  // Request path is purely combinational; a full FIFO blocks new requests
  assign out_req_val = !reset && w_grant_val && !w_full;
  assign out_req_msg = w_grant_port ? in1_req_msg : in0_req_msg;
  assign w_req_ok    = out_req_val && out_req_rdy;
  assign in0_req_rdy = w_req_ok && !w_grant_port;
  assign in1_req_rdy = w_req_ok &&  w_grant_port;
  assign w_req_fire  = w_req_ok;

  // Response path follows the oldest outstanding port ID
  assign w_head       = r_ids[r_rptr];
  assign w_resp_ok    = !reset && !w_empty;
  assign in0_resp_val = w_resp_ok && out_resp_val && !w_head;
  assign in1_resp_val = w_resp_ok && out_resp_val &&  w_head;
  assign out_resp_rdy = w_resp_ok && (w_head ? in1_resp_rdy : in0_resp_rdy);
  assign in0_resp_msg = out_resp_msg;
  assign in1_resp_msg = out_resp_msg;
  assign w_resp_fire  = out_resp_val && out_resp_rdy;

  // Tracking FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_req_fire)  r_wptr <= r_wptr + 1'b1;
      if (w_resp_fire) r_rptr <= r_rptr + 1'b1;
      case ({w_req_fire, w_resp_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Tracking FIFO storage; contents are meaningless until pushed
  always_ff @(posedge clk) begin
    if (w_req_fire) r_ids[r_wptr] <= w_grant_port;
  end

  // Round-robin pointer and stall lock
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio      <= 1'b0;
      r_lock      <= 1'b0;
      r_lock_port <= 1'b0;
    end else if (w_req_fire) begin
      r_prio <= !w_grant_port;
      r_lock <= 1'b0;
    end else if (out_req_val) begin
      r_lock      <= 1'b1;
      r_lock_port <= w_grant_port;
    end
  end

`ifndef SYNTHESIS
  a_count_bound:  assert property (@(posedge clk) disable iff (reset) r_count <= c_FULL_COUNT);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(w_resp_fire && w_empty));
`endif

endmodule
`default_nettype wire
